// File: rtl/lbm_streamer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : lbm_streamer                                             |
// | Description : Streams one cell's nine post-collision populations into  |
// |               the neighbour cells of a periodic lattice store.         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module lbm_streamer #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       f_new_null,
  input  logic [15:0]       f_new_n,
  input  logic [15:0]       f_new_ne,
  input  logic [15:0]       f_new_e,
  input  logic [15:0]       f_new_se,
  input  logic [15:0]       f_new_s,
  input  logic [15:0]       f_new_sw,
  input  logic [15:0]       f_new_w,
  input  logic [15:0]       f_new_nw,
  output logic              wr_en,
  input  logic              mem_ready,
  output logic [3:0]        wr_dir,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [XW-1:0] c_X_LAST   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] c_Y_LAST   = YW'(GRID_H - 1);
  localparam logic [3:0]    c_DIR_LAST = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_cx;
  logic [YW-1:0]   r_cy;
  logic [3:0]      r_dir;
  logic [15:0]     r_f [0:8];

  logic [XW-1:0]     w_xp;
  logic [XW-1:0]     w_xm;
  logic [YW-1:0]     w_yp;
  logic [YW-1:0]     w_ym;
  logic [XW-1:0]     w_nx;
  logic [YW-1:0]     w_ny;
  logic [3:0]        w_dir_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Periodic neighbour coordinates by compare/select, no modulo hardware.
  always_comb begin
    w_xp = (r_cx == c_X_LAST) ? '0 : r_cx + 1'b1;
    w_xm = (r_cx == '0) ? c_X_LAST : r_cx - 1'b1;
    w_yp = (r_cy == c_Y_LAST) ? '0 : r_cy + 1'b1;
    w_ym = (r_cy == '0) ? c_Y_LAST : r_cy - 1'b1;
  end

  // Address of the direction that will be presented after the next edge.
  always_comb begin
    w_dir_nxt = (r_state == S_WRITE) ? r_dir + 4'd1 : 4'd0;
    w_nx      = r_cx;
    w_ny      = r_cy;
    case (w_dir_nxt)
      4'd1: w_ny = w_yp;
      4'd2: begin w_nx = w_xp; w_ny = w_yp; end
      4'd3: w_nx = w_xp;
      4'd4: begin w_nx = w_xp; w_ny = w_ym; end
      4'd5: w_ny = w_ym;
      4'd6: begin w_nx = w_xm; w_ny = w_ym; end
      4'd7: w_nx = w_xm;
      4'd8: begin w_nx = w_xm; w_ny = w_yp; end
      default: ;
    endcase
    w_addr_nxt = ADDR_W'(w_ny) * ADDR_W'(GRID_W) + ADDR_W'(w_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_dir      <= 4'd0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_dir     <= 4'd0;
      wr_addr    <= '0;
      wr_data    <= 16'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_f[0]   <= f_new_null;
            r_f[1]   <= f_new_n;
            r_f[2]   <= f_new_ne;
            r_f[3]   <= f_new_e;
            r_f[4]   <= f_new_se;
            r_f[5]   <= f_new_s;
            r_f[6]   <= f_new_sw;
            r_f[7]   <= f_new_w;
            r_f[8]   <= f_new_nw;
            r_dir    <= 4'd0;
            wr_dir   <= 4'd0;
            wr_addr  <= w_addr_nxt;
            wr_data  <= f_new_null;
            wr_en    <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            r_state  <= S_WRITE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            if (r_dir != c_DIR_LAST) begin
              r_dir   <= w_dir_nxt;
              wr_dir  <= w_dir_nxt;
              wr_addr <= w_addr_nxt;
              wr_data <= r_f[w_dir_nxt];
            end else begin
              wr_en      <= 1'b0;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              r_state    <= S_IDLE;
              frame_done <= (r_cx == c_X_LAST) && (r_cy == c_Y_LAST);
              r_cx       <= w_xp;
              if (r_cx == c_X_LAST) begin
                r_cy <= w_yp;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbm_streamer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_lbm_streamer                                          |
// | Description : Directed self-checking bench for lbm_streamer, 4x4 grid. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_lbm_streamer;

  localparam int GW = 4;
  localparam int GH = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          mem_ready = 1'b1;
  logic [15:0]   f_in [0:8];
  logic          in_ready;
  logic          wr_en;
  logic [3:0]    wr_dir;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [3:0]    obs_dir  [0:15];
  logic [AW-1:0] obs_addr [0:15];
  logic [15:0]   obs_data [0:15];
  int            nw;

  always #5 clk = ~clk;

  lbm_streamer #(.GRID_W(GW), .GRID_H(GH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .f_new_null(f_in[0]), .f_new_n(f_in[1]), .f_new_ne(f_in[2]),
    .f_new_e(f_in[3]), .f_new_se(f_in[4]), .f_new_s(f_in[5]),
    .f_new_sw(f_in[6]), .f_new_w(f_in[7]), .f_new_nw(f_in[8]),
    .wr_en(wr_en), .mem_ready(mem_ready), .wr_dir(wr_dir),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int cx, input int cy, input int d);
    int dx [0:8];
    int dy [0:8];
    dx = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    dy = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
    return ((cy + dy[d] + GH) % GH) * GW + ((cx + dx[d] + GW) % GW);
  endfunction

  task automatic set_f(input logic [15:0] base);
    for (int i = 0; i < 9; i++) f_in[i] = base + 16'(i);
  endtask

  // Offers one cell, drives mem_ready (mode 1: 1,0,0,1 repeating) and records transfers.
  task automatic run_cell(input logic [15:0] base, input int mode, input bit chg,
                          output int period, output int fd, output int stall_err,
                          output bit tmo);
    int n;
    int cyc;
    bit mr;
    bit pstall;
    logic [28:0] snap;
    tmo = 1'b0; fd = 0; stall_err = 0; period = 0; nw = 0;
    pstall = 1'b0; snap = '0; n = 0;
    for (int i = 0; i < 16; i++) begin
      obs_dir[i] = 'x; obs_addr[i] = 'x; obs_data[i] = 'x;
    end
    while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (in_ready !== 1'b1) begin tmo = 1'b1; return; end
    set_f(base);
    in_valid = 1'b1;
    tick();
    if (!chg) in_valid = 1'b0;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 60) begin
      if (pstall && snap !== {wr_en, wr_dir, wr_addr, wr_data}) stall_err++;
      if (frame_done === 1'b1) fd++;
      mr = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      mem_ready = mr;
      if (wr_en === 1'b1 && mr) begin
        if (nw < 16) begin
          obs_dir[nw] = wr_dir; obs_addr[nw] = wr_addr; obs_data[nw] = wr_data;
        end
        nw++;
      end
      pstall = (wr_en === 1'b1) && !mr;
      snap = {wr_en, wr_dir, wr_addr, wr_data};
      if (chg) for (int i = 0; i < 9; i++) f_in[i] = ~(base + 16'(i)) ^ 16'(cyc);
      tick();
      cyc++;
    end
    if (in_ready !== 1'b1) tmo = 1'b1;
    if (frame_done === 1'b1) fd++;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    period = cyc + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_dir !== 4'd0) begin errors++; $display("FAIL reset_wr_dir: got %0d want 0", wr_dir); end
    checks++; if (wr_addr !== 8'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_cell00();
    int e00 [0:8];
    int per, fd, se;
    bit tmo;
    e00 = '{0, 4, 5, 1, 13, 12, 15, 3, 7};
    run_cell(16'h1000, 0, 1'b0, per, fd, se, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL cell00_timeout: got 1 want 0"); end
    checks++; if (nw != 9) begin errors++; $display("FAIL cell00_count: got %0d want 9", nw); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_dir[i] !== 4'(i) || obs_addr[i] !== 8'(e00[i]) || obs_data[i] !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL cell00_write%0d: got %0d:%0d:%h want %0d:%0d:%h", i,
                 obs_dir[i], obs_addr[i], obs_data[i], i, e00[i], 16'h1000 + 16'(i));
      end
    end
    checks++; if (per != 10) begin errors++; $display("FAIL cell00_period: got %0d want 10", per); end
    checks++; if (fd != 0) begin errors++; $display("FAIL cell00_frame_done: got %0d want 0", fd); end
  endtask

  task automatic test_stall();
    int per, fd, se;
    bit tmo;
    run_cell(16'h2000, 1, 1'b0, per, fd, se, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL stall_timeout: got 1 want 0"); end
    checks++; if (nw != 9) begin errors++; $display("FAIL stall_count: got %0d want 9", nw); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_dir[i] !== 4'(i) || obs_addr[i] !== 8'(exp_addr(1, 0, i)) || obs_data[i] !== 16'h2000 + 16'(i)) begin
        errors++;
        $display("FAIL stall_write%0d: got %0d:%0d:%h want %0d:%0d:%h", i,
                 obs_dir[i], obs_addr[i], obs_data[i], i, exp_addr(1, 0, i), 16'h2000 + 16'(i));
      end
    end
    checks++; if (se != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", se); end
    checks++; if (per != 18) begin errors++; $display("FAIL stall_period: got %0d want 18", per); end
  endtask

  task automatic test_hold_valid();
    int per, fd, se;
    bit tmo;
    run_cell(16'h3000, 0, 1'b1, per, fd, se, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL hold_timeout: got 1 want 0"); end
    checks++; if (nw != 9) begin errors++; $display("FAIL hold_count: got %0d want 9", nw); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_addr[i] !== 8'(exp_addr(2, 0, i)) || obs_data[i] !== 16'h3000 + 16'(i)) begin
        errors++;
        $display("FAIL hold_write%0d: got %0d:%h want %0d:%h", i,
                 obs_addr[i], obs_data[i], exp_addr(2, 0, i), 16'h3000 + 16'(i));
      end
    end
    checks++; if (per != 10) begin errors++; $display("FAIL hold_period: got %0d want 10", per); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL hold_no_extra: got wr_en %b want 0", wr_en); end
  endtask

  task automatic test_reset_mid();
    int e00 [0:8];
    int per, fd, se;
    bit tmo;
    e00 = '{0, 4, 5, 1, 13, 12, 15, 3, 7};
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    set_f(16'h4000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (4) tick();
    checks++; if (wr_dir !== 4'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_progress: got dir %0d busy %b want 4 1", wr_dir, busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (wr_en !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_reset: got wr_en %b in_ready %b want 0 0", wr_en, in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++; $display("FAIL rmid_release: got in_ready %b wr_en %b want 1 0", in_ready, wr_en); end
    run_cell(16'h5000, 0, 1'b0, per, fd, se, tmo);
    checks++; if (tmo || nw != 9) begin errors++; $display("FAIL rmid_next_count: got %0d tmo %b want 9 0", nw, tmo); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_addr[i] !== 8'(e00[i])) begin
        errors++; $display("FAIL rmid_next_addr%0d: got %0d want %0d", i, obs_addr[i], e00[i]);
      end
    end
  endtask

  task automatic test_full_sweep();
    int corner [0:8];
    int seen [0:8][0:15];
    int per, fd, se, fdtot, fdcell, total, bad, tmocnt, a;
    bit tmo;
    corner = '{15, 3, 0, 12, 8, 11, 10, 14, 2};
    for (int d = 0; d < 9; d++) for (int j = 0; j < 16; j++) seen[d][j] = 0;
    fdtot = 0; fdcell = -1; total = 0; bad = 0; tmocnt = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int c = 0; c < 16; c++) begin
      run_cell(16'(c * 16), 0, 1'b0, per, fd, se, tmo);
      if (tmo) tmocnt++;
      if (fd != 0) fdcell = c;
      fdtot += fd;
      total += nw;
      for (int i = 0; i < 9 && i < nw; i++) begin
        if (obs_dir[i] <= 4'd8 && obs_addr[i] < 8'd16) seen[obs_dir[i]][obs_addr[i]]++;
        a = exp_addr(c % GW, c / GW, i);
        checks++;
        if (obs_dir[i] !== 4'(i) || obs_addr[i] !== 8'(a) || obs_data[i] !== 16'(c * 16 + i)) begin
          errors++;
          $display("FAIL sweep_c%0d_w%0d: got %0d:%0d:%h want %0d:%0d:%h", c, i,
                   obs_dir[i], obs_addr[i], obs_data[i], i, a, 16'(c * 16 + i));
        end
        if (c == 15) begin
          checks++;
          if (obs_addr[i] !== 8'(corner[i])) begin
            errors++; $display("FAIL corner_addr%0d: got %0d want %0d", i, obs_addr[i], corner[i]);
          end
        end
      end
    end
    for (int d = 0; d < 9; d++) for (int j = 0; j < 16; j++) if (seen[d][j] != 1) bad++;
    checks++; if (tmocnt != 0) begin errors++; $display("FAIL sweep_timeout: got %0d want 0", tmocnt); end
    checks++; if (total != 144) begin errors++; $display("FAIL sweep_writes: got %0d want 144", total); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sweep_scoreboard: got %0d bad pairs want 0", bad); end
    checks++; if (fdtot != 1) begin errors++; $display("FAIL sweep_frame_count: got %0d want 1", fdtot); end
    checks++; if (fdcell != 15) begin errors++; $display("FAIL sweep_frame_cell: got %0d want 15", fdcell); end
  endtask

  task automatic test_wrap_after_frame();
    int e00 [0:8];
    int per, fd, se;
    bit tmo;
    e00 = '{0, 4, 5, 1, 13, 12, 15, 3, 7};
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_pulse_width: got %b want 0", frame_done); end
    run_cell(16'hA000, 0, 1'b0, per, fd, se, tmo);
    checks++; if (tmo || nw != 9) begin errors++; $display("FAIL wrap_count: got %0d tmo %b want 9 0", nw, tmo); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_addr[i] !== 8'(e00[i]) || obs_data[i] !== 16'hA000 + 16'(i)) begin
        errors++;
        $display("FAIL wrap_write%0d: got %0d:%h want %0d:%h", i, obs_addr[i], obs_data[i], e00[i], 16'hA000 + 16'(i));
      end
    end
    checks++; if (fd != 0) begin errors++; $display("FAIL wrap_frame_done: got %0d want 0", fd); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) f_in[i] = 16'd0;
    test_reset();
    test_cell00();
    test_stall();
    test_hold_valid();
    test_reset_mid();
    test_full_sweep();
    test_wrap_after_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lbm_streamer.md
# lbm_streamer

Receives post-collision populations from the collider, one lattice cell at a time, over a valid/ready handshake. It streams them into the lattice store by writing each of the nine values to the matching neighbour cell's direction plane. Neighbour addressing is periodic (wrap-around). The block sits between the collider output and the population memory write port, and marks the end of each lattice sweep.

## Interface
- GRID_W, 16, lattice width in cells (x), ≥2
- GRID_H, 16, lattice height in cells (y), ≥2
- ADDR_W, 8, cell address width; 2^ADDR_W ≥ GRID_W*GRID_H
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  collider presents a cell's nine populations
- in_ready  out  1  streamer can accept a cell
- f_new_null, f_new_n, f_new_ne, f_new_e, f_new_se, f_new_s, f_new_sw, f_new_w, f_new_nw  in  16 each  Q3.13 populations, sampled on acceptance
- wr_en  out  1  write request valid
- mem_ready  in  1  memory accepts the write this cycle
- wr_dir  out  4  direction plane 0..8 (null, n, ne, e, se, s, sw, w, nw)
- wr_addr  out  ADDR_W  destination cell address = y_dst*GRID_W + x_dst
- wr_data  out  16  population value, bit-exact copy of input
- frame_done  out  1  one-cycle pulse after the last cell of a sweep is fully written
- busy  out  1  high while in WRITE

## Operation
- Cells arrive in raster order: x fastest, then y, starting at (0,0). Internal counters cx, cy track the current cell.
- Direction offsets (dx,dy): null (0,0), n (0,+1), ne (+1,+1), e (+1,0), se (+1,−1), s (0,−1), sw (−1,−1), w (−1,0), nw (−1,+1). North is +y.
- Destination: x_dst = (cx+dx) mod GRID_W, y_dst = (cy+dy) mod GRID_H. Wrap is done by compare/select, not division:
  - x = GRID_W−1, dx = +1 → 0
  - x = 0, dx = −1 → GRID_W−1
  - same rule for y
- States:
  - IDLE: in_ready = 1, wr_en = 0. On in_valid && in_ready, latch all nine values, set dir = 0, go to WRITE.
  - WRITE: in_ready = 0, wr_en = 1, wr_dir = dir, wr_addr/wr_data for dir. A write transfers on the edge where wr_en && mem_ready. While mem_ready = 0, all write outputs hold stable. On a transfer with dir < 8, dir increments. On a transfer with dir = 8:
    - advance the cell counter: cx+1; at GRID_W−1 wrap to 0 and cy+1; at last cell wrap both to 0
    - return to IDLE
    - if the finished cell was (GRID_W−1, GRID_H−1), pulse frame_done in the next cycle
- Input data is never modified. Input changes while in WRITE are ignored.
- in_valid while in WRITE is not accepted and is not lost. The producer holds it until in_ready.

## Timing
- Reset (rst_n low at an edge): after that edge, in_ready = 0, wr_en = 0, wr_dir = 0, wr_addr = 0, wr_data = 0, frame_done = 0, busy = 0, state IDLE, cx = cy = dir = 0. in_ready becomes 1 after the first edge with rst_n high.
- All outputs are registered. No combinational path from in_valid or mem_ready to any output.
- Acceptance at edge E: wr_en = 1 with dir 0 in the cycle after E.
- With mem_ready held at 1, the nine writes occupy cycles E+1..E+9. in_ready = 1 again in cycle E+10, giving a minimum cell period of 10 cycles. Each mem_ready = 0 cycle adds one cycle.
- frame_done is asserted in the same cycle that in_ready returns after the final cell.
- Reset mid-WRITE: the latched cell is discarded and no further writes are issued. Counters restart at (0,0). Partially written neighbours are not rolled back.

## Test plan
- Cell (0,0) accepted, GRID 4×4, mem_ready = 1. Required (dir:addr) sequence: 0:0, 1:4, 2:5, 3:1, 4:13, 5:12, 6:15, 7:3, 8:7, with data matching each input. in_ready returns 10 cycles after acceptance.
- Corner cell (3,3), GRID 4×4. Required addresses: null 15, n 3, ne 0, e 12, se 8, s 11, sw 10, w 14, nw 2. frame_done pulses once, and the next accepted cell maps as (0,0).
- mem_ready toggles 1,0,0,1,… during a cell. Every write is issued exactly once, outputs are stable during stalls, and the cell period is 10 + number of stall cycles.
- Full 4×4 sweep of 16 cells with per-cell unique data (value = cell*16 + dir). A scoreboard sees 144 writes, each (dir, addr) pair exactly once, and exactly one frame_done.
- rst_n driven low after the 4th write of a cell. wr_en = 0 from the next cycle. in_ready = 1 one cycle after release. The next cell writes as (0,0).
- in_valid held high during WRITE with changing f inputs. Only the value present at the IDLE acceptance edge is written.
